// File: rtl/seq_matcher_if.sv
// rtl/seq_matcher_if.sv - key-write, symbol-stream and match-result bundle for seq_matcher
interface seq_matcher_if #(
  parameter int W     = 5,
  parameter int N     = 4,
  parameter int CNT_W = 8
);
  localparam int IDX_W  = $clog2(N);
  localparam int FILL_W = $clog2(N + 1);

  logic              key_we;
  logic [IDX_W-1:0]  key_idx;
  logic [W-1:0]      key_data;
  logic              in_valid;
  logic [W-1:0]      in_data;
  logic              in_ready;
  logic [FILL_W-1:0] fill;
  logic              match;
  logic [CNT_W-1:0]  match_cnt;

  modport master (
    output key_we, key_idx, key_data, in_valid, in_data,
    input  in_ready, fill, match, match_cnt
  );

  modport slave (
    input  key_we, key_idx, key_data, in_valid, in_data,
    output in_ready, fill, match, match_cnt
  );
endinterface

// File: rtl/seq_matcher.sv
// rtl/seq_matcher.sv - N-symbol streaming pattern detector built on the equality comparator
// Optional feature macro: SEQ_MATCHER_OVERLAP_EN (overlapping detection); default is non-overlapping.
module equality #(
  parameter int W = 5
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_eq
);
  assign o_eq = (i_a == i_b);
endmodule

module seq_matcher #(
  parameter int W     = 5,
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  seq_matcher_if.slave  bus
);
  localparam int IDX_W  = $clog2(N);
  localparam int FILL_W = $clog2(N + 1);
  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(N);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(N - 1);

  typedef enum logic {S_FILLING, S_ARMED} state_t;

  logic [W-1:0]      r_key  [N];
  logic [W-1:0]      r_hist [N];
  logic [FILL_W-1:0] r_fill;
  state_t            r_state;
  logic              r_acc;
  logic              r_match;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_ready;
  logic              w_accept;
  logic [N-1:0]      w_eq;
  logic              w_hit;
  logic              w_hit_acc;

  assign w_ready  = !rst && !bus.key_we;
  assign w_accept = bus.in_valid && w_ready;

  for (genvar g = 0; g < N; g++) begin : g_cmp
    equality #(.W(W)) u_eq (
      .i_a  (r_hist[g]),
      .i_b  (r_key[g]),
      .o_eq (w_eq[g])
    );
  end

  // ARMED tracks fill == N, so it doubles as the full-history qualifier.
  assign w_hit     = (&w_eq) && (r_state == S_ARMED);
  // A hit only counts on the cycle right after the symbol that produced it.
  assign w_hit_acc = r_acc && w_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        r_key[i]  <= '0;
        r_hist[i] <= '0;
      end
      r_fill  <= '0;
      r_state <= S_FILLING;
      r_acc   <= 1'b0;
      r_match <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_acc   <= w_accept;
      r_match <= w_hit_acc;
      if (r_match && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (bus.key_we) begin
        // Out-of-range slot indices match no slot; the flush still applies.
        for (int i = 0; i < N; i++) begin
          if (bus.key_idx == IDX_W'(i)) begin
            r_key[i] <= bus.key_data;
          end
        end
        r_fill  <= '0;
        r_state <= S_FILLING;
      end else begin
        if (w_accept) begin
          for (int i = 0; i < N - 1; i++) begin
            r_hist[i] <= r_hist[i+1];
          end
          r_hist[N-1] <= bus.in_data;
        end
`ifdef SEQ_MATCHER_OVERLAP_EN
        if (w_accept && (r_fill != FILL_MAX)) begin
          r_fill <= r_fill + 1'b1;
          if (r_fill == FILL_LAST) begin
            r_state <= S_ARMED;
          end
        end
`else
        // Flush wins over a symbol accepted on the same edge as the restart.
        if (w_hit_acc) begin
          r_fill  <= '0;
          r_state <= S_FILLING;
        end else if (w_accept && (r_fill != FILL_MAX)) begin
          r_fill <= r_fill + 1'b1;
          if (r_fill == FILL_LAST) begin
            r_state <= S_ARMED;
          end
        end
`endif
      end
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.fill      = r_fill;
  assign bus.match     = r_match;
  assign bus.match_cnt = r_cnt;
endmodule

// File: tb/tb_seq_matcher.sv
// tb/tb_seq_matcher.sv - directed self-checking bench for seq_matcher
module tb_seq_matcher;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

`ifdef SEQ_MATCHER_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  always #5 clk = ~clk;

  seq_matcher_if #(.W(5), .N(4), .CNT_W(8)) bus  ();
  seq_matcher_if #(.W(5), .N(4), .CNT_W(2)) sbus ();

  seq_matcher #(.W(5), .N(4), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  seq_matcher #(.W(5), .N(4), .CNT_W(2)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr_key(input logic [1:0] idx, input logic [4:0] data);
    bus.key_we   = 1'b1;
    bus.key_idx  = idx;
    bus.key_data = data;
    tick();
    bus.key_we   = 1'b0;
  endtask

  task automatic send(input logic [4:0] sym);
    bus.in_valid = 1'b1;
    bus.in_data  = sym;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic s_wr_key(input logic [1:0] idx, input logic [4:0] data);
    sbus.key_we   = 1'b1;
    sbus.key_idx  = idx;
    sbus.key_data = data;
    tick();
    sbus.key_we   = 1'b0;
  endtask

  task automatic s_send(input logic [4:0] sym);
    sbus.in_valid = 1'b1;
    sbus.in_data  = sym;
    tick();
    sbus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.key_we = 1'b0;  bus.key_idx = '0;  bus.key_data = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    sbus.key_we = 1'b0; sbus.key_idx = '0; sbus.key_data = '0;
    sbus.in_valid = 1'b0; sbus.in_data = '0;

    // reset held for two edges
    tick();
    chk("rst_fill",     32'(bus.fill),      0);
    chk("rst_match",    32'(bus.match),     0);
    chk("rst_cnt",      32'(bus.match_cnt), 0);
    chk("rst_in_ready", 32'(bus.in_ready),  0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 1);

    // basic match: key 1,2,3,4
    wr_key(2'd0, 5'd1); wr_key(2'd1, 5'd2); wr_key(2'd2, 5'd3); wr_key(2'd3, 5'd4);
    send(5'd1); send(5'd2); send(5'd3);
    chk("basic_fill3", 32'(bus.fill), 3);
    send(5'd4);
    chk("basic_fill4",        32'(bus.fill),  4);
    chk("basic_no_early_hit", 32'(bus.match), 0);
    tick();
    chk("basic_match",   32'(bus.match), 1);
    tick();
    chk("basic_pulse_end", 32'(bus.match),     0);
    chk("basic_cnt",       32'(bus.match_cnt), 1);

    // overlap: key 3,5,3,5 streamed 3,5,3,5,3,5
    do_reset();
    chk("ovl_rst_cnt", 32'(bus.match_cnt), 0);
    wr_key(2'd0, 5'd3); wr_key(2'd1, 5'd5); wr_key(2'd2, 5'd3); wr_key(2'd3, 5'd5);
    send(5'd3); send(5'd5); send(5'd3); send(5'd5);
    send(5'd3);
    chk("ovl_match4", 32'(bus.match), 1);
    chk("ovl_fill5",  32'(bus.fill),  OVL ? 4 : 0);
    send(5'd5);
    chk("ovl_match5", 32'(bus.match), 0);
    chk("ovl_fill6",  32'(bus.fill),  OVL ? 4 : 1);
    tick();
    chk("ovl_match6", 32'(bus.match), OVL ? 1 : 0);
    tick();
    chk("ovl_cnt", 32'(bus.match_cnt), OVL ? 2 : 1);

    // key write collides with a valid symbol
    bus.key_we   = 1'b1;
    bus.key_idx  = 2'd0;
    bus.key_data = 5'd3;
    bus.in_valid = 1'b1;
    bus.in_data  = 5'd9;
    #1;
    chk("coll_in_ready", 32'(bus.in_ready), 0);
    tick();
    bus.key_we   = 1'b0;
    bus.in_valid = 1'b0;
    chk("coll_fill", 32'(bus.fill), 0);
    send(5'd3); send(5'd5); send(5'd3);
    chk("coll_fill3", 32'(bus.fill), 3);
    send(5'd5);
    tick();
    chk("coll_match_after", 32'(bus.match), 1);

    // mismatch sweep over 2-bit values in slots 2..3 against an all-zero key
    do_reset();
    wr_key(2'd0, 5'd0); wr_key(2'd1, 5'd0); wr_key(2'd2, 5'd0); wr_key(2'd3, 5'd0);
    for (int v = 0; v < 16; v++) begin
      wr_key(2'd0, 5'd0);
      send(5'd0);
      send(5'd0);
      send(5'(v >> 2));
      send(5'(v & 3));
      tick();
      chk($sformatf("sweep_%0d", v), 32'(bus.match), (v == 0) ? 1 : 0);
    end
    tick();
    chk("sweep_cnt", 32'(bus.match_cnt), 1);

    // counter saturation on the 2-bit instance
    chk("sat_start_cnt", 32'(sbus.match_cnt), 0);
    s_wr_key(2'd0, 5'd7); s_wr_key(2'd1, 5'd7); s_wr_key(2'd2, 5'd7); s_wr_key(2'd3, 5'd7);
    for (int i = 0; i < 10; i++) begin
      s_send(5'd7);
    end
    tick();
    tick();
    chk("sat_cnt",  32'(sbus.match_cnt), OVL ? 3 : 2);
    chk("sat_fill", 32'(sbus.fill),      OVL ? 4 : 0);
    tick();
    tick();
    chk("sat_cnt_hold", 32'(sbus.match_cnt), OVL ? 3 : 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_matcher.md
# seq_matcher

Streaming pattern detector that sits downstream of the 5-bit `equality` comparator. It holds a programmable key of N symbols and a history of the last N accepted input symbols. It feeds each (history, key) slot pair through an `equality` instance and ANDs the results. It emits a one-cycle match pulse and keeps a saturating match count for the surrounding workshop designs.

## Interface
- `W`, default 5: symbol width; matches the `equality` operand width.
- `N`, default 4: key length and history depth. Legal range is 2..8.
- `CNT_W`, default 8: width of the match counter.

Ports:
- `clk`  in  1  system clock; everything is on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `key_we`  in  1  key write strobe.
- `key_idx`  in  $clog2(N)  key slot to write. Slot 0 is the oldest symbol of the pattern; slot N-1 is the newest.
- `key_data`  in  W  key symbol.
- `in_valid`  in  1  input symbol valid.
- `in_data`  in  W  input symbol.
- `in_ready`  out  1  block can accept a symbol this cycle.
- `fill`  out  $clog2(N+1)  number of valid history entries, 0..N.
- `match`  out  1  one-cycle pulse: the history equals the key.
- `match_cnt`  out  CNT_W  saturating count of match pulses.

## Operation
- A symbol is accepted when `in_valid && in_ready` on a rising edge.
- On acceptance:
  - history shifts by one; slot 0 drops out and `in_data` enters slot N-1;
  - `fill` increments, saturating at N.
- Key write:
  - when `key_we` is high on an edge, `key[key_idx]` <= `key_data`;
  - history is flushed in the same edge (`fill` <= 0);
  - `in_ready` = `!rst && !key_we`, so a write always wins over a simultaneous `in_valid` and that symbol is not accepted;
  - a `key_idx` >= N is ignored, but the flush still happens.
- Comparison:
  - N `equality` instances compare `hist[i]` against `key[i]`;
  - `hit` = AND of all N results, qualified by `fill == N`;
  - `hit` is evaluated on the history as it stands after the accepting edge.
- Match:
  - `match` is registered; it is high for exactly one cycle after each accepting edge that completes a hit;
  - `match` is never asserted on a cycle with no accepted symbol;
  - `match_cnt` increments with each `match` pulse and saturates at 2^CNT_W-1 (no wrap).
- State machine, derived from `fill`:
  - FILLING (`fill` < N): goes to ARMED when the N-th symbol is accepted.
  - ARMED (`fill` == N): stays ARMED on acceptance without a hit. Behaviour after a hit is set by the Configuration macro. Goes to FILLING on a key write.
- Reset: `rst` clears history, `fill`, key (all slots 0), `match` and `match_cnt`.

## Timing
- Reset values:
  - `in_ready` = 0 while `rst` is high, 1 on the first cycle after;
  - `fill` = 0, `match` = 0, `match_cnt` = 0.
- Latency: symbol accepted at edge k gives `match` high in the cycle after edge k+1 (one register stage after the history update). `match_cnt` updates one edge after `match`.
- Throughput: one symbol per cycle; `in_ready` drops only on `key_we` or `rst`.
- Reset mid-stream discards any `match` pending in the pipeline. No pulse is produced after `rst` deasserts.
- Key write while a match is pending: the pending `match` still fires; the history flush does not cancel it.
- Boundaries:
  - `fill` never exceeds N;
  - `match_cnt` holds at all-ones;
  - key of all zeros is legal and matches N accepted zero symbols.

## Configuration
- `SEQ_MATCHER_OVERLAP_EN` defined:
  - overlapping detection; after a hit, `fill` stays N and the state stays ARMED;
  - each subsequent accepted symbol can produce another match.
- Not defined:
  - non-overlapping detection; the edge after a hit sets `fill` <= 0 (state goes to FILLING);
  - the next match needs N fresh symbols.

## Test plan
- Reset check: hold `rst` for 2 cycles, then release. Require `fill`=0, `match`=0, `match_cnt`=0 during reset, and `in_ready`=1 from the first cycle after release.
- Basic match: write key 1,2,3,4, stream 1,2,3,4. Require exactly one `match` pulse, one cycle after the edge after the 4th symbol, and `match_cnt`=1.
- Overlap: key 3,5,3,5, stream 3,5,3,5,3,5.
  - With `SEQ_MATCHER_OVERLAP_EN`: matches after the 4th and 6th symbols, `match_cnt`=2.
  - Without it: one match, `match_cnt`=1.
- Key write collision: assert `key_we` and `in_valid` together. Require `in_ready`=0, the symbol dropped, and `fill`=0 on the next cycle.
- Mismatch sweep: key 0,0,0,0, stream all 16 combinations of 2-bit values in slots 2..3 with zeros in slots 0..1. Require a match only for 0,0,0,0.
- Saturation: with `CNT_W`=2, key 7,7,7,7, overlap enabled, stream 10 sevens. Require `match_cnt` to stop at 3.
